// File: rtl/ctl_sseg_mux_pkg.sv
// Shared display definitions: hex-to-segment table, blanking constants and
// the shadow snapshot type used by the multiplexed 7-segment driver.
package ctl_sseg_mux_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic [3:0][3:0] hex;
    logic [3:0]      dp_en;
    logic            blz;
  } shadow_t;

endpackage

// File: rtl/ctl_sseg_mux_if.sv
// Display bus: digit values and options toward the driver, anode/segment
// drives back out. The master side produces the digit data.
interface ctl_sseg_mux_if;
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] dp_en;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  // No handshake: inputs are level data sampled at frame boundaries,
  // outputs are continuously driven registered levels.
  modport master (output hex0, hex1, hex2, hex3, dp_en, blank_lz,
                  input  an, seg, dp);
  modport slave  (input  hex0, hex1, hex2, hex3, dp_en, blank_lz,
                  output an, seg, dp);
endinterface

// File: rtl/ctl_sseg_dec.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
module ctl_sseg_dec
  import ctl_sseg_mux_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ctl_sseg_mux.sv
// Four-digit time-multiplexed 7-segment driver with per-frame shadow capture,
// leading-zero blanking and per-digit decimal points.
module ctl_sseg_mux
  import ctl_sseg_mux_pkg::*;
#(
  parameter int DIV = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  ctl_sseg_mux_if.slave     disp
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  slot_t         idx;
  logic          tick;
  logic          load_first;
  shadow_t       sh;
  logic [3:0]    cur_hex;
  logic [6:0]    dec_seg;
  logic          blank;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // Shadows only change at a frame boundary (or right after reset), so a
  // frame never mixes old and new digit values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      load_first <= 1'b1;
    end else begin
      load_first <= 1'b0;
      if (load_first || (tick && idx == 2'd3)) begin
        sh.hex   <= {disp.hex3, disp.hex2, disp.hex1, disp.hex0};
        sh.dp_en <= disp.dp_en;
        sh.blz   <= disp.blank_lz;
      end
    end
  end

  assign cur_hex = sh.hex[idx];

  // A digit is blanked only if it and every digit to its left are zero.
  always_comb begin
    blank = 1'b0;
    if (sh.blz) begin
      case (idx)
        2'd3:    blank = (sh.hex[3] == 4'd0);
        2'd2:    blank = (sh.hex[3] == 4'd0) && (sh.hex[2] == 4'd0);
        2'd1:    blank = (sh.hex[3] == 4'd0) && (sh.hex[2] == 4'd0) &&
                         (sh.hex[1] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  ctl_sseg_dec u_dec (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst || blank) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= dec_seg;
      dp_q  <= ~sh.dp_en[idx];
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule

// File: doc/ctl_sseg_mux.md
CTL_SSEG_MUX -- requirements
Module: ctl_sseg_mux

Interface
REQ-001 Parameter DIV, default 100_000, means clocks per digit slot; DIV >= 2.
REQ-002 clk  in  1  system clock; single clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 hex0..hex3  in  4 each  digit values, hex0 = rightmost; hex2/hex3 come from the score counter, and hex0/hex1 from other game status.
REQ-005 dp_en  in  4  decimal-point enable per digit, active-high, bit i = digit i.
REQ-006 blank_lz  in  1  leading-zero blanking enable.
REQ-007 an  out  4  digit anodes, active-low, bit i = digit i.
REQ-008 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  out  1  decimal point, active-low.

Function
REQ-010 div_cnt SHALL count 0..DIV-1 each clk and wrap to 0; tick = (div_cnt == DIV-1).
REQ-011 idx (2 bits) SHALL increment on tick, wrapping 3->0; one scan frame = 4*DIV clocks.
REQ-012 The shadow registers sh0..sh3, sh_dp and sh_blz SHALL load hex0..hex3, dp_en and blank_lz on the first clock after reset release and on every tick with idx==3; at all other times they hold, so frames are tear-free.
REQ-013 an, seg and dp SHALL be registered decodes of current idx and shadow, one clock of latency behind idx.
REQ-014 Active slot: an = one-hot-low at bit idx, unless that digit is blanked, in which case an = 4'b1111.
REQ-015 seg SHALL be the standard hex decode of sh[idx], active-low: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
REQ-016 dp SHALL equal ~sh_dp[idx]; it is forced to 1 when the digit is blanked.
REQ-017 With sh_blz=1: digit3 blanked if sh3==0; digit2 blanked if sh3==0 and sh2==0; digit1 blanked if sh3, sh2 and sh1 are all 0; digit0 never blanked.
REQ-018 With sh_blz=0, no digit SHALL be blanked.
REQ-019 When blanked, seg SHALL be 7Fh.
REQ-020 Inputs changing mid-frame SHALL NOT affect outputs until the next frame.

Reset
REQ-021 On rst: div_cnt=0, idx=0, shadows=0, an=4'b1111, seg=7Fh, dp=1.
REQ-022 Reset mid-frame SHALL abort the scan; the scan restarts at idx 0 with a fresh shadow load on the first clock after release.
REQ-023 The first output cycle after release MAY show the reset shadow (digit0 = 40h); from the second cycle on, outputs reflect the loaded inputs.

Structure
REQ-024 The 16-entry segment decode table and the SEG_OFF (7Fh) and AN_OFF (4'hF) constants SHALL live in a shared display package for reuse by other display blocks.
REQ-025 The hex-to-7-segment decode SHALL be a combinational sub-module, ctl_sseg_dec (4-bit in, 7-bit active-low out).
REQ-026 The divider width SHALL be $clog2(DIV).

Verification (DIV=4)
REQ-027 Hold rst 3 clocks -> an=1111, seg=7Fh, dp=1 throughout; release -> an=1110 within 2 clocks.
REQ-028 Set hex3..0=1,2,3,4 and blank_lz=0 -> an cycles 1110, 1101, 1011, 0111, 4 clocks each, with seg 19h, 30h, 24h, 79h respectively; the pattern repeats every 16 clocks.
REQ-029 Set hex3..0=0,0,0,7 and blank_lz=1 -> an=1111 and seg=7Fh in slots 3..1; slot 0 shows an=1110, seg=78h. With all hex values 0, only digit0 shows 40h.
REQ-030 Change hex0 from 4 to 9 while idx==1 -> digit0 shows 19h until the wrap, then 10h in the next frame.
REQ-031 Assert rst while idx==2 -> the next clock gives an=1111, seg=7Fh; after release the scan restarts at digit0 and div_cnt starts from 0.
REQ-032 Set dp_en=0100 and blank_lz=0 -> dp=0 only during the digit2 slot and 1 in all other slots.
